sirkit_solver: RTL and testbench
================================

Name: sirkit_solver

Overview:
- Initiator for the byte-oracle interface: drives `byte_num`/`byte_guess` into a combinational checker and samples `guess_valid`.
- Recovers the stored secret one byte at a time by linear search over a guess range.
- Buffers recovered bytes in an internal 32x8 store, readable after completion.
- Sits beside the oracle in the challenge harness and self-test bench, replacing host-side brute force.

Parameters:
- NUM_BYTES, 32: bytes to probe; 1..32.
- ADDR_W, 5: width of `byte_num`/`rd_addr`; equals clog2(32).
- GUESS_LO, 8'h20: first guess per byte.
- GUESS_HI, 8'h7E: last guess per byte; GUESS_LO <= GUESS_HI; 8'hFF legal.
- STOP_CHAR, 8'h7D ("}"): a match on this value ends the run early when `stop_en`=1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset.
- start  in  1  single-cycle run request.
- stop_en  in  1  enables early termination on STOP_CHAR; sampled at start acceptance.
- byte_num  out  ADDR_W  oracle index, registered.
- byte_guess  out  8  oracle guess, registered.
- guess_valid  in  1  oracle response, combinational from the two outputs above.
- busy  out  1  high in PROBE.
- done  out  1  level, high in DONE.
- error  out  1  sticky; at least one byte had no match this run.
- len  out  ADDR_W+1  bytes written this run, including the terminator.
- miss_mask  out  NUM_BYTES  bit i set if byte i had no match.
- rd_addr  in  ADDR_W  readout index.
- rd_data  out  8  mem[rd_addr], registered, 1-cycle latency.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- On rst: state IDLE; byte_num=0; byte_guess=GUESS_LO; busy=0; done=0; error=0; len=0; miss_mask=0; mem all 0x00; rd_data=0x00.
- FSM states: IDLE, PROBE, DONE.
- IDLE: outputs held at their reset values.
  - start=1 -> PROBE. Clears mem, error, len and miss_mask; sets idx=0, guess=GUESS_LO; latches stop_en.
- PROBE: one guess per cycle. guess_valid is sampled in the same cycle the registered byte_num/byte_guess are presented.
  - Match, guess_valid=1: mem[idx]<=guess; len<=idx+1.
    - If (stop latched and guess==STOP_CHAR) or idx==NUM_BYTES-1 -> DONE.
    - Else idx++, guess<=GUESS_LO.
  - No match, guess!=GUESS_HI: guess++.
  - No match, guess==GUESS_HI: mem[idx]<=0x00; miss_mask[idx]<=1; error<=1; len<=idx+1.
    - If idx==NUM_BYTES-1 -> DONE, else idx++, guess<=GUESS_LO.
  - Equality is checked before increment, so GUESS_HI=8'hFF never wraps.
- Latency: a byte whose value v is in range resolves in (v-GUESS_LO+1) cycles; an out-of-range byte takes (GUESS_HI-GUESS_LO+1) cycles.
- DONE: done=1; byte_num/byte_guess frozen at the last probe.
  - start=1 -> restart exactly as from IDLE (done drops the next cycle).
- start during PROBE is ignored.
- rst mid-PROBE aborts: state IDLE, all reset values, partial results discarded.
- Readout: rd_data valid the cycle after rd_addr in any state. Reads mid-PROBE return partial contents; not an error.
- rd_addr >= NUM_BYTES returns 0x00.

Decomposition:
- Package `sirkit_pkg`:
  - state enum {IDLE, PROBE, DONE};
  - constants FLAG_MAX_BYTES=32, PRINTABLE_LO=8'h20, PRINTABLE_HI=8'h7E, FLAG_TERM=8'h7D, PAD_CHAR=8'h58.
- No sub-module. The 32x8 result store is inline; clearing on start needs single-cycle clear, so it is not a RAM macro.

Test Plan:
- Full run: checker secret "DUCTF{51r_y35_s1r_c0ec4d}" padded with "X", stop_en=1, start -> busy for exactly 1350 cycles, then done=1; len=25; error=0; rd_addr 0..24 returns the secret bytes.
- First byte timing: same setup -> mem[0]=0x44 written on probe cycle 37; byte_num steps 0->1 the next cycle with byte_guess=0x20.
- stop_en=0: same secret -> runs all 32 bytes; len=32; bytes 25..31 read 0x58; done after 1350+7*57=1749 cycles.
- Miss: test oracle byte 3 = 0x19 -> byte 3 takes 95 cycles; miss_mask[3]=1; error=1; mem[3]=0x00; later bytes still recovered.
- Abort/restart: rst asserted at probe cycle 500 -> next cycle IDLE, len=0, mem 0x00. start in DONE restarts and gives identical results. start pulses mid-PROBE change nothing.

Source files
------------

// File: rtl/sirkit_pkg.sv
// Shared types and constants for the byte-oracle solver.
package sirkit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int          FLAG_MAX_BYTES = 32;
   localparam logic [7:0]  PRINTABLE_LO   = 8'h20;
   localparam logic [7:0]  PRINTABLE_HI   = 8'h7E;
   localparam logic [7:0]  FLAG_TERM      = 8'h7D;
   localparam logic [7:0]  PAD_CHAR       = 8'h58;

endpackage

// File: rtl/sirkit_solver.sv
// Oracle initiator: recovers a secret byte by byte through a linear guess
// sweep against a combinational checker and keeps the result in a small store.
module sirkit_solver
   import sirkit_pkg::*;
#(
   parameter int         NUM_BYTES = FLAG_MAX_BYTES,
   parameter int         ADDR_W    = 5,
   parameter logic [7:0] GUESS_LO  = PRINTABLE_LO,
   parameter logic [7:0] GUESS_HI  = PRINTABLE_HI,
   parameter logic [7:0] STOP_CHAR = FLAG_TERM
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop_en,
   output logic [ADDR_W-1:0]    byte_num,
   output logic [7:0]           byte_guess,
   input  logic                 guess_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_W:0]      len,
   output logic [NUM_BYTES-1:0] miss_mask,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [7:0]           rd_data
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [7:0]            guess_q, guess_d;
   logic                  stopEn_q, stopEn_d;
   logic                  error_q, error_d;
   logic [ADDR_W:0]       len_q, len_d;
   logic [NUM_BYTES-1:0]  missMask_q, missMask_d;
   logic [7:0]            mem_q [NUM_BYTES];
   logic [7:0]            mem_d [NUM_BYTES];
   logic [7:0]            rdData_q, rdData_d;
   logic                  lastByte;

   assign lastByte = (idx_q == ADDR_W'(NUM_BYTES - 1));

   // Next-state logic: start clears the run state, PROBE advances one guess per cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      guess_d    = guess_q;
      stopEn_d   = stopEn_q;
      error_d    = error_q;
      len_d      = len_q;
      missMask_d = missMask_q;
      mem_d      = mem_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = PROBE;
               mem_d      = '{default: '0};
               error_d    = 1'b0;
               len_d      = '0;
               missMask_d = '0;
               idx_d      = '0;
               guess_d    = GUESS_LO;
               stopEn_d   = stop_en;
            end
         end
         PROBE: begin
            if (guess_valid) begin
               mem_d[idx_q] = guess_q;
               len_d        = {1'b0, idx_q} + (ADDR_W+1)'(1);
               if ((stopEn_q && (guess_q == STOP_CHAR)) || lastByte) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  guess_d = GUESS_LO;
               end
            end else if (guess_q == GUESS_HI) begin
               mem_d[idx_q]      = 8'h00;
               missMask_d[idx_q] = 1'b1;
               error_d           = 1'b1;
               len_d             = {1'b0, idx_q} + (ADDR_W+1)'(1);
               if (lastByte) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  guess_d = GUESS_LO;
               end
            end else begin
               guess_d = guess_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Readout path: addresses past the probed range read as zero.
   always_comb begin
      rdData_d = 8'h00;
      if ({1'b0, rd_addr} < (ADDR_W+1)'(NUM_BYTES)) begin
         rdData_d = mem_q[rd_addr];
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         guess_q    <= GUESS_LO;
         stopEn_q   <= 1'b0;
         error_q    <= 1'b0;
         len_q      <= '0;
         missMask_q <= '0;
         mem_q      <= '{default: '0};
         rdData_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         guess_q    <= guess_d;
         stopEn_q   <= stopEn_d;
         error_q    <= error_d;
         len_q      <= len_d;
         missMask_q <= missMask_d;
         mem_q      <= mem_d;
         rdData_q   <= rdData_d;
      end
   end

   assign byte_num   = idx_q;
   assign byte_guess = guess_q;
   assign busy       = (state_q == PROBE);
   assign done       = (state_q == DONE);
   assign error      = error_q;
   assign len        = len_q;
   assign miss_mask  = missMask_q;
   assign rd_data    = rdData_q;

endmodule

// File: tb/tb_sirkit_solver.sv
// Self-checking bench for sirkit_solver with a behavioural oracle.
module tb_sirkit_solver;

   localparam int         NB  = 32;
   localparam int         AW  = 5;
   localparam logic [7:0] LO  = 8'h20;
   localparam logic [7:0] HI  = 8'h7E;
   localparam logic [7:0] TRM = 8'h7D;

   typedef struct {
      bit         stopEn;
      int         overIdx;
      logic [7:0] overVal;
      int         expCycles;
      int         expLen;
      bit         expErr;
      logic [31:0] expMask;
   } runVec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            stop_en;
   logic [AW-1:0]   byte_num;
   logic [7:0]      byte_guess;
   logic            guess_valid;
   logic            busy;
   logic            done;
   logic            error;
   logic [AW:0]     len;
   logic [NB-1:0]   miss_mask;
   logic [AW-1:0]   rd_addr;
   logic [7:0]      rd_data;

   logic [7:0]      secret [NB];
   string           baseFlag = "DUCTF{51r_y35_s1r_c0ec4d}";
   runVec_t         vecs [5];
   runVec_t         sbQueue [$];
   int              nApplied = 0;
   int              nMiscompares = 0;

   sirkit_solver dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop_en     (stop_en),
      .byte_num    (byte_num),
      .byte_guess  (byte_guess),
      .guess_valid (guess_valid),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .len         (len),
      .miss_mask   (miss_mask),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   // Combinational oracle.
   assign guess_valid = (byte_guess == secret[byte_num]);

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setSecret(input int overIdx, input logic [7:0] overVal);
      for (int i = 0; i < NB; i++) begin
         secret[i] = (i < baseFlag.len()) ? baseFlag[i] : 8'h58;
      end
      if (overIdx >= 0) secret[overIdx] = overVal;
   endtask

   task automatic applyStimulus(input runVec_t v);
      setSecret(v.overIdx, v.overVal);
      sbQueue.push_back(v);
      @(negedge clk);
      start   = 1'b1;
      stop_en = v.stopEn;
      @(negedge clk);
      start   = 1'b0;
      stop_en = 1'b0;
      checkOutput("done_drops_after_start", {63'd0, done}, 64'd0);
      checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic collectRun();
      runVec_t    e;
      int         cycles;
      logic [7:0] expByte;
      logic [7:0] expGuess;
      cycles = 0;
      while (busy && cycles < 5000) begin
         cycles++;
         start = (cycles == 100);
         @(negedge clk);
      end
      start = 1'b0;
      e = sbQueue.pop_front();
      checkOutput("busy_cycles", 64'(cycles), 64'(e.expCycles));
      checkOutput("done", {63'd0, done}, 64'd1);
      checkOutput("len", 64'(len), 64'(e.expLen));
      checkOutput("error", {63'd0, error}, {63'd0, e.expErr});
      checkOutput("miss_mask", 64'(miss_mask), 64'(e.expMask));
      expGuess = (secret[e.expLen-1] >= LO && secret[e.expLen-1] <= HI) ? secret[e.expLen-1] : HI;
      checkOutput("byte_num_frozen", 64'(byte_num), 64'(e.expLen - 1));
      checkOutput("byte_guess_frozen", 64'(byte_guess), 64'(expGuess));
      for (int i = 0; i < NB; i++) begin
         rd_addr = AW'(i);
         @(negedge clk);
         expByte = 8'h00;
         if (i < e.expLen && secret[i] >= LO && secret[i] <= HI) expByte = secret[i];
         checkOutput($sformatf("rd_data[%0d]", i), 64'(rd_data), 64'(expByte));
      end
   endtask

   task automatic waitDone();
      int c;
      c = 0;
      while (!done && c < 5000) begin
         c++;
         @(negedge clk);
      end
      checkOutput("wait_done_timeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      // Table: stop_en, override idx/value, cycles, len, error, mask.
      vecs[0] = '{1'b1, -1, 8'h00, 1350, 25, 1'b0, 32'h0};
      vecs[1] = '{1'b0, -1, 8'h00, 1749, 32, 1'b0, 32'h0};
      vecs[2] = '{1'b1,  0, 8'h7D,   94,  1, 1'b0, 32'h0};
      vecs[3] = '{1'b1,  3, 8'h19, 1392, 25, 1'b1, 32'h0000_0008};
      vecs[4] = '{1'b0, 31, 8'h80, 1787, 32, 1'b1, 32'h8000_0000};

      rst = 1'b1; start = 1'b0; stop_en = 1'b0; rd_addr = '0;
      setSecret(-1, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_done", {63'd0, done}, 64'd0);
      checkOutput("rst_error", {63'd0, error}, 64'd0);
      checkOutput("rst_len", 64'(len), 64'd0);
      checkOutput("rst_mask", 64'(miss_mask), 64'd0);
      checkOutput("rst_byte_num", 64'(byte_num), 64'd0);
      checkOutput("rst_byte_guess", 64'(byte_guess), 64'(LO));
      checkOutput("rst_rd_data", 64'(rd_data), 64'd0);

      // First byte timing: 0x44 matches on probe cycle 37.
      @(negedge clk);
      start = 1'b1; stop_en = 1'b1;
      @(negedge clk);
      start = 1'b0; stop_en = 1'b0;
      rd_addr = '0;
      for (int k = 1; k < 37; k++) @(negedge clk);
      checkOutput("c37_byte_num", 64'(byte_num), 64'd0);
      checkOutput("c37_byte_guess", 64'(byte_guess), 64'h44);
      @(negedge clk);
      checkOutput("c38_byte_num", 64'(byte_num), 64'd1);
      checkOutput("c38_byte_guess", 64'(byte_guess), 64'h20);
      checkOutput("c38_rd_data_prewrite", 64'(rd_data), 64'd0);
      @(negedge clk);
      checkOutput("c39_rd_data", 64'(rd_data), 64'h44);
      waitDone();

      // Abort via reset at probe cycle 500.
      @(negedge clk);
      start = 1'b1; stop_en = 1'b1;
      @(negedge clk);
      start = 1'b0; stop_en = 1'b0;
      for (int k = 1; k < 500; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", {63'd0, busy}, 64'd0);
      checkOutput("abort_done", {63'd0, done}, 64'd0);
      checkOutput("abort_len", 64'(len), 64'd0);
      checkOutput("abort_byte_num", 64'(byte_num), 64'd0);
      checkOutput("abort_byte_guess", 64'(byte_guess), 64'(LO));
      for (int i = 0; i < 8; i++) begin
         rd_addr = AW'(i);
         @(negedge clk);
         checkOutput($sformatf("abort_mem[%0d]", i), 64'(rd_data), 64'd0);
      end

      // Table-driven runs, back to back (each later run restarts from DONE).
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v]);
         collectRun();
      end

      // Restart from DONE gives identical results.
      applyStimulus(vecs[0]);
      collectRun();

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
      $finish;
   end

endmodule
